// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the arbitrated register RAM.
package ram_arbiter_pkg;

  localparam int DefaultDataWidth = 16;
  localparam int DefaultNumRegs   = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/RAM.sv
// Simple register RAM: one synchronous write port, one asynchronous read port.
module RAM
  import ram_arbiter_pkg::*;
#(
  parameter int DataWidth  = DefaultDataWidth,
  parameter int NumRegs    = DefaultNumRegs,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  writeEn,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [DataWidth-1:0]  writeData,
  input  logic [IndexWidth-1:0] readAddr,
  output logic [DataWidth-1:0]  readData
);

  logic [DataWidth-1:0] mem_r [NumRegs];

  // Storage write
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem_r[writeAddr] <= writeData;
    end
  end

  assign readData = mem_r[readAddr];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin picker; search starts just after lastGrant.
module rr_arbiter #(
  parameter int NumReqs  = 2,
  parameter int IdxWidth = (NumReqs > 1) ? $clog2(NumReqs) : 1
) (
  input  logic [NumReqs-1:0]  reqValid,
  input  logic [IdxWidth-1:0] lastGrant,
  input  logic                enable,
  output logic [NumReqs-1:0]  grant,
  output logic [IdxWidth-1:0] grantIdx
);

  logic                found_s;
  logic [IdxWidth-1:0] cand_s;

  // Rotating priority search, then one-hot expansion of the winner
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 1; k <= NumReqs; k++) begin
      cand_s = IdxWidth'((int'(lastGrant) + k) % NumReqs);
      if (!found_s && reqValid[cand_s]) begin
        found_s  = 1'b1;
        grantIdx = cand_s;
      end else begin
        grantIdx = grantIdx;
      end
    end
    if (enable && found_s) begin
      grant[grantIdx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM between NumReqs requesters; zero-sweeps the RAM after reset or clear.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DataWidth  = DefaultDataWidth,
  parameter int NumRegs    = DefaultNumRegs,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int NumReqs    = 2
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                clearReq,
  input  logic [NumReqs-1:0]                  reqValid,
  input  logic [NumReqs-1:0]                  reqWrite,
  input  logic [NumReqs-1:0][IndexWidth-1:0]  reqAddr,
  input  logic [NumReqs-1:0][DataWidth-1:0]   reqWData,
  output logic [NumReqs-1:0]                  reqReady,
  output logic [NumReqs-1:0]                  rspValid,
  output logic [DataWidth-1:0]                rspData,
  output logic                                initDone
);

  localparam int GrantWidth = (NumReqs > 1) ? $clog2(NumReqs) : 1;

  arb_state_t             state_r;
  logic [IndexWidth-1:0]  init_count_r;
  logic [GrantWidth-1:0]  last_grant_r;
  logic [GrantWidth-1:0]  grant_idx_s;
  logic [NumReqs-1:0]     grant_s;
  logic [NumReqs-1:0]     rsp_valid_r;
  logic [DataWidth-1:0]   rsp_data_r;
  logic                   init_done_r;
  logic                   arb_enable_s;
  logic                   accept_s;
  logic                   ram_we_s;
  logic [IndexWidth-1:0]  ram_waddr_s;
  logic [DataWidth-1:0]   ram_wdata_s;
  logic [DataWidth-1:0]   read_data_s;

  // A clear request blocks grants in the same cycle it is seen
  assign arb_enable_s = (state_r == RUN) && !clearReq;
  assign accept_s     = |grant_s;

  rr_arbiter #(
    .NumReqs  (NumReqs),
    .IdxWidth (GrantWidth)
  ) u_rr (
    .reqValid  (reqValid),
    .lastGrant (last_grant_r),
    .enable    (arb_enable_s),
    .grant     (grant_s),
    .grantIdx  (grant_idx_s)
  );

  // Write-port mux: sweep owns the port in INIT, granted requester in RUN
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    if (state_r == INIT) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = init_count_r;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = accept_s && reqWrite[grant_idx_s];
      ram_waddr_s = reqAddr[grant_idx_s];
      ram_wdata_s = reqWData[grant_idx_s];
    end
  end

  RAM #(
    .DataWidth  (DataWidth),
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth)
  ) u_ram (
    .clk       (clk),
    .writeEn   (ram_we_s),
    .writeAddr (ram_waddr_s),
    .writeData (ram_wdata_s),
    .readAddr  (reqAddr[grant_idx_s]),
    .readData  (read_data_s)
  );

  // Sweep sequencing, round-robin bookkeeping and the registered read response
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= INIT;
      init_count_r <= '0;
      last_grant_r <= GrantWidth'(NumReqs - 1);
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      init_done_r  <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          rsp_valid_r <= '0;
          if (init_count_r == IndexWidth'(NumRegs - 1)) begin
            state_r      <= RUN;
            init_count_r <= '0;
            init_done_r  <= 1'b1;
          end else begin
            init_count_r <= init_count_r + IndexWidth'(1);
          end
        end
        RUN: begin
          if (clearReq) begin
            state_r     <= INIT;
            init_done_r <= 1'b0;
            rsp_valid_r <= '0;
          end else if (accept_s) begin
            last_grant_r <= grant_idx_s;
            if (reqWrite[grant_idx_s]) begin
              rsp_valid_r <= '0;
            end else begin
              rsp_valid_r <= grant_s;
              rsp_data_r  <= read_data_s;
            end
          end else begin
            rsp_valid_r <= '0;
          end
        end
        default: begin
          state_r      <= INIT;
          init_count_r <= '0;
          init_done_r  <= 1'b0;
          rsp_valid_r  <= '0;
        end
      endcase
    end
  end

  assign reqReady = grant_s;
  assign rspValid = rsp_valid_r;
  assign rspData  = rsp_data_r;
  assign initDone = init_done_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int NQ = 2;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic                   clearReq;
  logic [NQ-1:0]          reqValid;
  logic [NQ-1:0]          reqWrite;
  logic [NQ-1:0][AW-1:0]  reqAddr;
  logic [NQ-1:0][DW-1:0]  reqWData;
  logic [NQ-1:0]          reqReady;
  logic [NQ-1:0]          rspValid;
  logic [DW-1:0]          rspData;
  logic                   initDone;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NR];
  int            m_last;
  bit            m_run;
  int            m_init_left;
  logic [NQ-1:0] m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic [NQ-1:0] exp_ready;

  ram_arbiter #(
    .DataWidth  (DW),
    .NumRegs    (NR),
    .IndexWidth (AW),
    .NumReqs    (NQ)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .clearReq (clearReq),
    .reqValid (reqValid),
    .reqWrite (reqWrite),
    .reqAddr  (reqAddr),
    .reqWData (reqWData),
    .reqReady (reqReady),
    .rspValid (rspValid),
    .rspData  (rspData),
    .initDone (initDone)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_run       = 1'b0;
    m_init_left = NR;
    m_last      = NQ - 1;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
  endtask

  // Expected grant: first valid requester searching upward from last winner
  task automatic model_eval();
    exp_ready = '0;
    if (m_run && !clearReq) begin
      for (int k = 1; k <= NQ; k++) begin
        int c;
        c = (m_last + k) % NQ;
        if (exp_ready == '0 && reqValid[c]) exp_ready[c] = 1'b1;
      end
    end
  endtask

  // Advance the model across one rising edge; returns 1 ns after the edge
  task automatic model_tick();
    int g;
    logic [NQ-1:0] nv;
    @(posedge clk);
    model_eval();
    g  = -1;
    nv = '0;
    for (int i = 0; i < NQ; i++) if (exp_ready[i]) g = i;
    if (!m_run) begin
      m_init_left--;
      if (m_init_left == 0) m_run = 1'b1;
    end else if (clearReq) begin
      m_run       = 1'b0;
      m_init_left = NR;
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
    end else if (g >= 0) begin
      m_last = g;
      if (reqWrite[g]) begin
        m_mem[reqAddr[g]] = reqWData[g];
      end else begin
        nv[g]      = 1'b1;
        m_rsp_data = m_mem[reqAddr[g]];
      end
    end
    m_rsp_valid = nv;
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    reqValid[i] = v;
    reqWrite[i] = w;
    reqAddr[i]  = a;
    reqWData[i] = d;
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    clearReq = 1'b0;
    reqValid = 2'b11;
    reqWrite = 2'b00;
    reqAddr  = '0;
    reqWData = '0;
    model_reset();
    #3;
    tests_run++;
    if ({reqReady, rspValid, rspData, initDone} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b rspValid=%b rspData=%h initDone=%b, want all 0",
               reqReady, rspValid, rspData, initDone);
    end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int c = 0; c < NR; c++) begin
      #2;
      tests_run++;
      if (reqReady !== 2'b00 || initDone !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_no_grant cyc%0d: ready=%b initDone=%b, want 00/0", c, reqReady, initDone);
      end
      model_tick();
    end
    tests_run++;
    if (initDone !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_done_rise: initDone=%b, want 1", initDone);
    end
    for (int a = 0; a < NR; a++) begin
      reqValid = 2'b00;
      set_req(0, 1'b1, 1'b0, AW'(a), '0);
      model_eval();
      #2;
      tests_run++;
      if (reqReady !== 2'b01) begin
        tests_failed++;
        $display("FAIL sweep_ready a%0d: ready=%b, want 01", a, reqReady);
      end
      model_tick();
      tests_run++;
      if (rspValid !== 2'b01 || rspData !== 16'h0000) begin
        tests_failed++;
        $display("FAIL sweep_zero a%0d: rspValid=%b rspData=%h, want 01/0000", a, rspValid, rspData);
      end
    end
    reqValid = 2'b00;
  endtask

  task automatic test_round_robin();
    reqValid = 2'b00;
    set_req(0, 1'b1, 1'b1, 3'd1, 16'h1111);
    model_tick();
    reqValid = 2'b00;
    set_req(1, 1'b1, 1'b1, 3'd2, 16'h2222);
    model_tick();
    set_req(0, 1'b1, 1'b0, 3'd1, '0);
    set_req(1, 1'b1, 1'b0, 3'd2, '0);
    for (int i = 0; i < 6; i++) begin
      logic [NQ-1:0] want;
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      tests_run++;
      if (reqReady !== want) begin
        tests_failed++;
        $display("FAIL rr_grant i%0d: ready=%b, want %b", i, reqReady, want);
      end
      model_tick();
      tests_run++;
      if (rspValid !== want || rspData !== ((i % 2 == 0) ? 16'h1111 : 16'h2222)) begin
        tests_failed++;
        $display("FAIL rr_rsp i%0d: rspValid=%b rspData=%h, want %b", i, rspValid, rspData, want);
      end
    end
    reqValid = 2'b00;
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b1, 1'b1, 3'd3, 16'hBEEF);
    model_tick();
    tests_run++;
    if (rspValid !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr_no_rsp: rspValid=%b, want 00", rspValid);
    end
    reqValid = 2'b00;
    set_req(1, 1'b1, 1'b0, 3'd3, '0);
    #2;
    tests_run++;
    if (reqReady !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_ready: ready=%b, want 10", reqReady);
    end
    model_tick();
    tests_run++;
    if (rspValid !== 2'b10 || rspData !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL b2b_rsp: rspValid=%b rspData=%h, want 10/beef", rspValid, rspData);
    end
    reqValid = 2'b00;
  endtask

  task automatic test_clear();
    set_req(0, 1'b1, 1'b1, 3'd5, 16'h1234);
    model_tick();
    set_req(0, 1'b1, 1'b0, 3'd5, '0);
    model_tick();
    clearReq = 1'b1;
    reqValid = 2'b11;
    reqWrite = 2'b00;
    #2;
    tests_run++;
    if (reqReady !== 2'b00 || rspValid !== 2'b01 || rspData !== 16'h1234) begin
      tests_failed++;
      $display("FAIL clear_cycle: ready=%b rspValid=%b rspData=%h, want 00/01/1234",
               reqReady, rspValid, rspData);
    end
    model_tick();
    for (int c = 0; c < NR; c++) begin
      clearReq = (c == 3 || c == 4);
      #2;
      tests_run++;
      if (initDone !== 1'b0 || reqReady !== 2'b00 || rspValid !== 2'b00) begin
        tests_failed++;
        $display("FAIL clear_init cyc%0d: initDone=%b ready=%b rspValid=%b, want 0/00/00",
                 c, initDone, reqReady, rspValid);
      end
      model_tick();
    end
    clearReq = 1'b0;
    tests_run++;
    if (initDone !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_done: initDone=%b, want 1", initDone);
    end
    reqValid = 2'b00;
    set_req(0, 1'b1, 1'b0, 3'd5, '0);
    model_tick();
    tests_run++;
    if (rspValid !== 2'b01 || rspData !== 16'h0000) begin
      tests_failed++;
      $display("FAIL clear_readback: rspValid=%b rspData=%h, want 01/0000", rspValid, rspData);
    end
    reqValid = 2'b00;
  endtask

  task automatic test_stall();
    set_req(1, 1'b1, 1'b0, 3'd0, '0);
    model_tick();
    set_req(0, 1'b1, 1'b0, 3'd6, '0);
    set_req(1, 1'b1, 1'b1, 3'd7, 16'h5A5A);
    #2;
    tests_run++;
    if (reqReady !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_first: ready=%b, want 01", reqReady);
    end
    model_tick();
    reqValid[0] = 1'b0;
    #2;
    tests_run++;
    if (reqReady !== 2'b10) begin
      tests_failed++;
      $display("FAIL stall_next: ready=%b, want 10", reqReady);
    end
    model_tick();
    tests_run++;
    if (rspValid !== 2'b00) begin
      tests_failed++;
      $display("FAIL stall_wr_rsp: rspValid=%b, want 00", rspValid);
    end
    reqValid = 2'b00;
    set_req(0, 1'b1, 1'b0, 3'd7, '0);
    model_tick();
    tests_run++;
    if (rspValid !== 2'b01 || rspData !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL stall_readback: rspValid=%b rspData=%h, want 01/5a5a", rspValid, rspData);
    end
    reqValid = 2'b00;
  endtask

  task automatic test_async_reset();
    set_req(0, 1'b1, 1'b0, 3'd7, '0);
    model_tick();
    #1;
    resetN = 1'b0;
    #1;
    tests_run++;
    if (rspValid !== 2'b00 || reqReady !== 2'b00 || initDone !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: rspValid=%b ready=%b initDone=%b, want 00/00/0",
               rspValid, reqReady, initDone);
    end
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int c = 0; c < NR; c++) begin
      #2;
      tests_run++;
      if (rspValid !== 2'b00 || reqReady !== 2'b00) begin
        tests_failed++;
        $display("FAIL post_reset cyc%0d: rspValid=%b ready=%b, want 00/00", c, rspValid, reqReady);
      end
      model_tick();
    end
    tests_run++;
    if (initDone !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_done: initDone=%b, want 1", initDone);
    end
    reqValid = 2'b00;
  endtask

  task automatic test_random();
    logic [NQ-1:0] acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NQ; i++) begin
        if (!reqValid[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
                  DW'($urandom));
        end
      end
      clearReq = ($urandom_range(0, 49) == 0);
      model_eval();
      #2;
      tests_run++;
      if (reqReady !== exp_ready) begin
        tests_failed++;
        $display("FAIL rand_ready cyc%0d: ready=%b, want %b", cyc, reqReady, exp_ready);
      end
      model_tick();
      acc = exp_ready;
      tests_run++;
      if (rspValid !== m_rsp_valid || rspData !== m_rsp_data || initDone !== m_run) begin
        tests_failed++;
        $display("FAIL rand_rsp cyc%0d: rspValid=%b rspData=%h initDone=%b, want %b/%h/%b",
                 cyc, rspValid, rspData, initDone, m_rsp_valid, m_rsp_data, m_run);
      end
      for (int i = 0; i < NQ; i++) if (acc[i]) reqValid[i] = 1'b0;
    end
    clearReq = 1'b0;
    reqValid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
